// File: rtl/excp_commit_pkg.sv
`default_nettype none
// excp_commit_pkg: exception codes, csr_bus layout and FSM encoding shared by the commit arbiter.
package excp_commit_pkg;

  localparam int ECODE_W    = 6;
  localparam int ESUB_W     = 9;
  localparam int CSR_BUS_WD = 82;

  localparam logic [ECODE_W-1:0] ECODE_INT  = 6'h00;
  localparam logic [ECODE_W-1:0] ECODE_ADEF = 6'h08;
  localparam logic [ECODE_W-1:0] ECODE_ALE  = 6'h09;
  localparam logic [ECODE_W-1:0] ECODE_SYS  = 6'h0B;
  localparam logic [ECODE_W-1:0] ECODE_BRK  = 6'h0C;
  localparam logic [ECODE_W-1:0] ECODE_INE  = 6'h0D;
  localparam logic [ESUB_W-1:0]  ESUB_NONE  = '0;

  // Field order is what the CSR file decodes, MSB first.
  typedef struct packed {
    logic               is_etrn;
    logic               in_excp;
    logic [ECODE_W-1:0] ecode;
    logic [ESUB_W-1:0]  esubcode;
    logic [31:0]        era;
    logic               use_badv;
    logic [31:0]        bad_vaddr;
  } csr_bus_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_ISSUE = 2'd2,
    S_RETRY = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/excp_prio_enc.sv
`default_nettype none
// excp_prio_enc: per-slot priority encoder turning one instruction's flags into a csr_bus event.
module excp_prio_enc
  import excp_commit_pkg::*;
(
  input  logic        valid,
  input  logic        intr,
  input  logic        adef,
  input  logic        ine,
  input  logic        sys,
  input  logic        brk,
  input  logic        ale,
  input  logic        ertn,
  input  logic [31:0] pc,
  input  logic [31:0] badv,
  output logic        hit,
  output logic        is_excp,
  output csr_bus_t    evt
);

  always_comb begin
    evt     = '0;
    is_excp = 1'b1;
    if (intr) begin
      evt.ecode = ECODE_INT;
    end else if (adef) begin
      evt.ecode     = ECODE_ADEF;
      evt.esubcode  = ESUB_NONE;
      evt.use_badv  = 1'b1;
      evt.bad_vaddr = pc;
    end else if (ine) begin
      evt.ecode = ECODE_INE;
    end else if (sys) begin
      evt.ecode = ECODE_SYS;
    end else if (brk) begin
      evt.ecode = ECODE_BRK;
    end else if (ale) begin
      evt.ecode     = ECODE_ALE;
      evt.use_badv  = 1'b1;
      evt.bad_vaddr = badv;
    end else begin
      is_excp     = 1'b0;
      evt.is_etrn = ertn;
    end
    evt.in_excp = is_excp;
    evt.era     = pc;
    // An invalid slot carries no event regardless of its flags.
    if (!valid) begin
      evt     = '0;
      is_excp = 1'b0;
    end
    hit = is_excp | evt.is_etrn;
  end

endmodule
`default_nettype wire

// File: rtl/excp_commit.sv
`default_nettype none
// excp_commit: picks the oldest exception/ERTN in the commit pair, drains memory,
// issues the registered csr_bus for one cycle and retries when the CSR file rejects it.
module excp_commit
  import excp_commit_pkg::*;
#(
  parameter int DRAIN_MAX = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            cm_valid,
  input  logic [63:0]           cm_pc,
  input  logic [1:0]            cm_adef,
  input  logic [1:0]            cm_ine,
  input  logic [1:0]            cm_sys,
  input  logic [1:0]            cm_brk,
  input  logic [1:0]            cm_ale,
  input  logic [1:0]            cm_ertn,
  input  logic [63:0]           cm_badv,
  input  logic                  have_intrpt,
  input  logic                  mem_busy,
  input  logic                  jump_excp_fail,
  output logic [CSR_BUS_WD-1:0] csr_bus,
  output logic [1:0]            commit_kill,
  output logic                  flush,
  output logic                  stall
);

  localparam int CNT_W = $clog2(DRAIN_MAX + 1);

  csr_bus_t         evt0, evt1, sel_evt, evt_q, bus_q;
  logic             hit0, hit1, exc0, exc1, any_hit;
  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;

  excp_prio_enc u_slot0 (
    .valid(cm_valid[0]), .intr(have_intrpt), .adef(cm_adef[0]), .ine(cm_ine[0]),
    .sys(cm_sys[0]), .brk(cm_brk[0]), .ale(cm_ale[0]), .ertn(cm_ertn[0]),
    .pc(cm_pc[31:0]), .badv(cm_badv[31:0]),
    .hit(hit0), .is_excp(exc0), .evt(evt0)
  );

  excp_prio_enc u_slot1 (
    .valid(cm_valid[1]), .intr(1'b0), .adef(cm_adef[1]), .ine(cm_ine[1]),
    .sys(cm_sys[1]), .brk(cm_brk[1]), .ale(cm_ale[1]), .ertn(cm_ertn[1]),
    .pc(cm_pc[63:32]), .badv(cm_badv[63:32]),
    .hit(hit1), .is_excp(exc1), .evt(evt1)
  );

  assign any_hit = hit0 | hit1;
  assign sel_evt = hit0 ? evt0 : evt1;

  always_comb begin
    next_state  = state;
    commit_kill = 2'b00;
    case (state)
      S_IDLE: begin
        if (any_hit) begin
          next_state  = mem_busy ? S_DRAIN : S_ISSUE;
          // An ERTN retires itself; an exception kills itself; slot1 always dies behind slot0.
          commit_kill = hit0 ? {1'b1, exc0} : {exc1, 1'b0};
        end
      end
      S_DRAIN: if (!mem_busy || cnt == CNT_W'(DRAIN_MAX)) next_state = S_ISSUE;
      S_ISSUE: next_state = jump_excp_fail ? S_RETRY : S_IDLE;
      S_RETRY: next_state = S_ISSUE;
      default: next_state = S_IDLE;
    endcase
    if (!rst) commit_kill = 2'b00;
  end

  assign stall   = (state != S_IDLE);
  assign flush   = (state == S_ISSUE) && !jump_excp_fail;
  assign csr_bus = bus_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      evt_q <= '0;
      bus_q <= '0;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (state == S_IDLE && any_hit) evt_q <= sel_evt;
      if (next_state == S_ISSUE) bus_q <= (state == S_IDLE) ? sel_evt : evt_q;
      else                       bus_q <= '0;
      // The count includes the first drain cycle, so a stuck mem_busy yields DRAIN_MAX drain cycles.
      if (state == S_IDLE)                                 cnt <= (any_hit && mem_busy) ? CNT_W'(1) : '0;
      else if (state == S_DRAIN && next_state == S_DRAIN) cnt <= cnt + 1'b1;
      else                                                 cnt <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_excp_commit.sv
`default_nettype none
// tb_excp_commit: directed and randomized transactions checked against a transaction-level model.
module tb_excp_commit;
  import excp_commit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cm_valid, cm_adef, cm_ine, cm_sys, cm_brk, cm_ale, cm_ertn;
  logic [63:0] cm_pc, cm_badv;
  logic        have_intrpt, mem_busy, jump_excp_fail;
  logic [81:0] csr_bus;
  logic [1:0]  commit_kill;
  logic        flush, stall;

  excp_commit #(.DRAIN_MAX(15)) dut (
    .clk(clk), .rst(rst), .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_adef(cm_adef),
    .cm_ine(cm_ine), .cm_sys(cm_sys), .cm_brk(cm_brk), .cm_ale(cm_ale), .cm_ertn(cm_ertn),
    .cm_badv(cm_badv), .have_intrpt(have_intrpt), .mem_busy(mem_busy),
    .jump_excp_fail(jump_excp_fail), .csr_bus(csr_bus), .commit_kill(commit_kill),
    .flush(flush), .stall(stall)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Stimulus for the transaction being presented in the idle cycle.
  logic [1:0]  s_valid, s_adef, s_ine, s_sys, s_brk, s_ale, s_ertn;
  logic [31:0] s_pc0, s_pc1, s_badv0, s_badv1;
  logic        s_intr;

  task automatic check(input string tag, input logic [81:0] got, input logic [81:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Event kind of one slot: ecode for an exception, 100 for ERTN, -1 for none.
  function automatic int slot_kind(input bit v, input bit intr, input bit adef, input bit ine,
                                   input bit sys, input bit brk, input bit ale, input bit ertn);
    if (!v)   return -1;
    if (intr) return 0;
    if (adef) return 8;
    if (ine)  return 13;
    if (sys)  return 11;
    if (brk)  return 12;
    if (ale)  return 9;
    if (ertn) return 100;
    return -1;
  endfunction

  function automatic logic [81:0] mk_bus(input int kind, input logic [31:0] pc, input logic [31:0] badv);
    logic [31:0] bv;
    if (kind == 100) return {1'b1, 1'b0, 6'd0, 9'd0, pc, 1'b0, 32'd0};
    bv = (kind == 8) ? pc : ((kind == 9) ? badv : 32'd0);
    return {1'b0, 1'b1, 6'(kind), 9'd0, pc, 1'((kind == 8) || (kind == 9)), bv};
  endfunction

  task automatic clear_stim();
    s_valid = 2'b11; s_adef = '0; s_ine = '0; s_sys = '0; s_brk = '0; s_ale = '0; s_ertn = '0;
    s_pc0 = 32'h1c00_0100; s_pc1 = 32'h1c00_0104; s_badv0 = '0; s_badv1 = '0; s_intr = 1'b0;
  endtask

  task automatic drive_stim();
    cm_valid = s_valid; cm_adef = s_adef; cm_ine = s_ine; cm_sys = s_sys; cm_brk = s_brk;
    cm_ale = s_ale; cm_ertn = s_ertn; cm_pc = {s_pc1, s_pc0}; cm_badv = {s_badv1, s_badv0};
    have_intrpt = s_intr;
  endtask

  task automatic drive_junk();
    cm_valid = 2'($urandom); cm_adef = 2'($urandom); cm_ine = 2'($urandom); cm_sys = 2'($urandom);
    cm_brk = 2'($urandom); cm_ale = 2'($urandom); cm_ertn = 2'($urandom);
    cm_pc = {$urandom, $urandom}; cm_badv = {$urandom, $urandom}; have_intrpt = 1'($urandom);
  endtask

  // B = leading cycles of mem_busy starting at the idle cycle, F = rejected issues before acceptance.
  task automatic run_txn(input int B, input int F);
    int          k0, k1, d;
    logic [81:0] eb;
    logic [1:0]  ek;
    bit          hit;
    k0 = slot_kind(s_valid[0], s_intr, s_adef[0], s_ine[0], s_sys[0], s_brk[0], s_ale[0], s_ertn[0]);
    k1 = slot_kind(s_valid[1], 1'b0, s_adef[1], s_ine[1], s_sys[1], s_brk[1], s_ale[1], s_ertn[1]);
    eb = '0; ek = 2'b00;
    if (k0 != -1) begin
      eb = mk_bus(k0, s_pc0, s_badv0); ek = {1'b1, 1'(k0 != 100)};
    end else if (k1 != -1) begin
      eb = mk_bus(k1, s_pc1, s_badv1); ek = {1'(k1 != 100), 1'b0};
    end
    hit = (k0 != -1) || (k1 != -1);

    @(negedge clk);
    drive_stim(); mem_busy = (B > 0); jump_excp_fail = 1'($urandom); #1;
    check("idle_kill",  82'(commit_kill), 82'(ek));
    check("idle_stall", 82'(stall), 82'(0));
    check("idle_flush", 82'(flush), 82'(0));
    check("idle_bus",   csr_bus, 82'(0));
    if (!hit) return;

    d = (B > 15) ? 15 : B;
    for (int i = 1; i <= d; i++) begin
      @(negedge clk);
      drive_junk(); mem_busy = (i < B); jump_excp_fail = 1'($urandom); #1;
      check("drain_stall", 82'(stall), 82'(1));
      check("drain_bus",   csr_bus, 82'(0));
      check("drain_kill",  82'(commit_kill), 82'(0));
      check("drain_flush", 82'(flush), 82'(0));
    end

    for (int k = 0; k <= F; k++) begin
      @(negedge clk);
      drive_junk(); mem_busy = 1'($urandom); jump_excp_fail = (k < F); #1;
      check("issue_bus",   csr_bus, eb);
      check("issue_flush", 82'(flush), 82'(k == F));
      check("issue_stall", 82'(stall), 82'(1));
      check("issue_kill",  82'(commit_kill), 82'(0));
      if (csr_bus[81] && csr_bus[80]) check("bus_etrn_excp", 82'(csr_bus[81:80]), 82'(2'b10));
      if (k < F) begin
        @(negedge clk);
        drive_junk(); jump_excp_fail = 1'($urandom); #1;
        check("retry_bus",   csr_bus, 82'(0));
        check("retry_flush", 82'(flush), 82'(0));
        check("retry_stall", 82'(stall), 82'(1));
      end
    end
  endtask

  function automatic logic [1:0] rnd_flag();
    return {1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0)};
  endfunction

  initial begin
    rst = 1'b0;
    clear_stim(); s_valid = '0; drive_stim(); mem_busy = 1'b0; jump_excp_fail = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_bus",   csr_bus, 82'(0));
    check("rst_kill",  82'(commit_kill), 82'(0));
    check("rst_flush", 82'(flush), 82'(0));
    check("rst_stall", 82'(stall), 82'(0));
    @(negedge clk); rst = 1'b1;

    // SYS in slot0
    clear_stim(); s_sys = 2'b01; run_txn(0, 0);
    // ALE in slot1 behind a clean slot0
    clear_stim(); s_ale = 2'b10; s_badv1 = 32'h0000_0003; run_txn(0, 0);
    // interrupt beats INE in slot0
    clear_stim(); s_intr = 1'b1; s_ine = 2'b01; run_txn(0, 0);
    // ERTN in slot0 waiting on memory
    clear_stim(); s_ertn = 2'b01; run_txn(4, 0);
    // rejected first issue
    clear_stim(); s_sys = 2'b01; run_txn(0, 1);
    // stuck mem_busy forces issue
    clear_stim(); s_brk = 2'b10; s_adef = 2'b10; run_txn(40, 0);
    // ADEF in slot0, ERTN in slot1 with slot0 invalid
    clear_stim(); s_adef = 2'b01; s_ale = 2'b01; run_txn(1, 2);
    clear_stim(); s_valid = 2'b10; s_ertn = 2'b11; s_intr = 1'b1; run_txn(0, 0);

    // reset while draining
    clear_stim(); s_sys = 2'b01;
    @(negedge clk); drive_stim(); mem_busy = 1'b1;
    repeat (3) begin @(negedge clk); drive_junk(); end
    @(negedge clk); rst = 1'b0; drive_junk(); #1;
    check("mrst_bus",   csr_bus, 82'(0));
    check("mrst_kill",  82'(commit_kill), 82'(0));
    check("mrst_flush", 82'(flush), 82'(0));
    check("mrst_stall", 82'(stall), 82'(0));
    @(negedge clk); rst = 1'b1; clear_stim(); s_valid = '0; drive_stim(); mem_busy = 1'b0; #1;
    check("post_rst_stall", 82'(stall), 82'(0));
    check("post_rst_bus",   csr_bus, 82'(0));

    for (int n = 0; n < 300; n++) begin
      s_valid = 2'($urandom); s_adef = rnd_flag(); s_ine = rnd_flag(); s_sys = rnd_flag();
      s_brk = rnd_flag(); s_ale = rnd_flag(); s_ertn = rnd_flag();
      s_pc0 = $urandom; s_pc1 = $urandom; s_badv0 = $urandom; s_badv1 = $urandom;
      s_intr = 1'($urandom_range(0, 7) == 0);
      run_txn(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 20)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    clear_stim(); s_valid = '0; run_txn(0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
